ex_branch_resolve: RTL and testbench

- Consumer end of the ALU result/flag interface in the execute stage of the RISC-V pipeline.
- Registers the ALU result and flags into the EX/MEM boundary.
- Resolves conditional branches and JAL/JALR from the flags and issues a one-cycle PC redirect.
- Squashes wrong-path instructions for a fixed number of accepted slots after a taken redirect.

---
 rtl/ex_branch_resolve_if.sv | 43 ++++
 rtl/ex_branch_resolve.sv | 120 ++++++++++++
 tb/tb_ex_branch_resolve.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_branch_resolve_if.sv
// rtl/ex_branch_resolve_if.sv - EX-stage operand/flag inputs and EX/MEM, redirect outputs of branch resolve
interface ex_branch_resolve_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             valid_i;
    logic             stall_i;
    logic             branch_i;
    logic             jal_i;
    logic             jalr_i;
    logic [2:0]       funct3_i;
    logic [WIDTH-1:0] pc_i;
    logic [WIDTH-1:0] imm_i;
    logic [4:0]       rd_i;
    logic             reg_write_i;
    logic [WIDTH-1:0] alu_result_i;
    logic             zero_i;
    logic             negative_i;
    logic             carry_i;
    logic             over_flow_i;

    logic             mem_valid_o;
    logic [WIDTH-1:0] mem_result_o;
    logic [4:0]       mem_rd_o;
    logic             mem_reg_write_o;
    logic             redirect_o;
    logic [WIDTH-1:0] redirect_pc_o;
    logic [CNT_W-1:0] taken_cnt_o;

    modport master (
        output valid_i, stall_i, branch_i, jal_i, jalr_i, funct3_i, pc_i, imm_i,
               rd_i, reg_write_i, alu_result_i, zero_i, negative_i, carry_i, over_flow_i,
        input  mem_valid_o, mem_result_o, mem_rd_o, mem_reg_write_o,
               redirect_o, redirect_pc_o, taken_cnt_o
    );

    modport slave (
        input  valid_i, stall_i, branch_i, jal_i, jalr_i, funct3_i, pc_i, imm_i,
               rd_i, reg_write_i, alu_result_i, zero_i, negative_i, carry_i, over_flow_i,
        output mem_valid_o, mem_result_o, mem_rd_o, mem_reg_write_o,
               redirect_o, redirect_pc_o, taken_cnt_o
    );
endinterface

// File: rtl/ex_branch_resolve.sv
// rtl/ex_branch_resolve.sv - EX-stage branch/jump resolution, EX/MEM register and wrong-path squash
module ex_branch_resolve #(
    parameter int WIDTH       = 32,
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_W       = 16
) (
    input logic              clk,
    input logic              rst_n,
    ex_branch_resolve_if.slave ex
);
    typedef enum logic [0:0] {RUN, KILL} state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_SLOTS);

    state_t           state, state_nxt;
    logic [2:0]       kill_cnt, kill_cnt_nxt;
    logic             accept, killed, issue;
    logic             eq, lt, ltu, cond, taken, is_jump;
    logic [WIDTH-1:0] target, link;

    logic             mem_valid_q;
    logic [WIDTH-1:0] mem_result_q;
    logic [4:0]       mem_rd_q;
    logic             mem_reg_write_q;
    logic             redirect_q;
    logic [WIDTH-1:0] redirect_pc_q;
    logic [CNT_W-1:0] taken_cnt_q;

    // Branch compare from subtract flags: carry=1 means a >= b unsigned.
    always_comb begin
        eq      = ex.zero_i;
        lt      = ex.negative_i ^ ex.over_flow_i;
        ltu     = ~ex.carry_i;
        cond    = 1'b0;
        case (ex.funct3_i)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt;
            3'b101:  cond = ~lt;
            3'b110:  cond = ltu;
            3'b111:  cond = ~ltu;
            default: cond = 1'b0;
        endcase
        is_jump = ex.jal_i | ex.jalr_i;
        taken   = is_jump | (ex.branch_i & cond);
        if (ex.jalr_i)
            target = {ex.alu_result_i[WIDTH-1:1], 1'b0};
        else
            target = ex.pc_i + ex.imm_i;
        link    = ex.pc_i + WIDTH'(4);
    end

    assign accept = ex.valid_i & ~ex.stall_i;

    always_comb begin
        state_nxt    = state;
        kill_cnt_nxt = kill_cnt;
        issue        = 1'b0;
        killed       = 1'b0;
        case (state)
            RUN: begin
                if (accept && taken) begin
                    issue        = 1'b1;
                    state_nxt    = KILL;
                    kill_cnt_nxt = FLUSH_INIT;
                end
            end
            KILL: begin
                killed = 1'b1;
                if (accept) begin
                    kill_cnt_nxt = kill_cnt - 3'd1;
                    if (kill_cnt == 3'd1)
                        state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            kill_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            kill_cnt <= kill_cnt_nxt;
        end
    end

    // A stall freezes the whole EX/MEM boundary, including a pending redirect pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_valid_q     <= 1'b0;
            mem_result_q    <= '0;
            mem_rd_q        <= 5'd0;
            mem_reg_write_q <= 1'b0;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
            taken_cnt_q     <= '0;
        end else if (!ex.stall_i) begin
            mem_valid_q     <= accept & ~killed;
            mem_result_q    <= is_jump ? link : ex.alu_result_i;
            mem_rd_q        <= ex.rd_i;
            mem_reg_write_q <= accept & ~killed & ex.reg_write_i & (is_jump | ~ex.branch_i);
            redirect_q      <= issue;
            if (issue)
                redirect_pc_q <= target;
            if (issue && !(&taken_cnt_q))
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
        end
    end

    assign ex.mem_valid_o     = mem_valid_q;
    assign ex.mem_result_o    = mem_result_q;
    assign ex.mem_rd_o        = mem_rd_q;
    assign ex.mem_reg_write_o = mem_reg_write_q;
    assign ex.redirect_o      = redirect_q;
    assign ex.redirect_pc_o   = redirect_pc_q;
    assign ex.taken_cnt_o     = taken_cnt_q;
endmodule

// File: tb/tb_ex_branch_resolve.sv
// tb/tb_ex_branch_resolve.sv - directed vector bench for ex_branch_resolve
module tb_ex_branch_resolve;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ex_branch_resolve_if #(.WIDTH(32), .CNT_W(16)) bus ();
    ex_branch_resolve_if #(.WIDTH(32), .CNT_W(4))  sat ();

    ex_branch_resolve #(.WIDTH(32), .FLUSH_SLOTS(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex(bus.slave));
    ex_branch_resolve #(.WIDTH(32), .FLUSH_SLOTS(1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ex(sat.slave));

    typedef struct {
        logic        valid, branch, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] pc, imm;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu;
        logic        z, n, c, o;
        logic        e_mv;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        logic        e_rw, e_redir;
        logic [31:0] e_rpc;
        logic [15:0] e_cnt;
        logic        chk;
    } vec_t;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    vec_t vecs[26];

    function automatic vec_t fill(input logic [31:0] alu, input logic [4:0] rd, input logic [15:0] cnt);
        vec_t v;
        v = '{T, F, F, F, 3'b000, 32'h0, 32'h0, rd, T, alu, F, F, F, F,
              F, 32'h0, rd, F, F, 32'h0, cnt, F};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.valid_i      = v.valid;
        bus.stall_i      = 1'b0;
        bus.branch_i     = v.branch;
        bus.jal_i        = v.jal;
        bus.jalr_i       = v.jalr;
        bus.funct3_i     = v.f3;
        bus.pc_i         = v.pc;
        bus.imm_i        = v.imm;
        bus.rd_i         = v.rd;
        bus.reg_write_i  = v.rw;
        bus.alu_result_i = v.alu;
        bus.zero_i       = v.z;
        bus.negative_i   = v.n;
        bus.carry_i      = v.c;
        bus.over_flow_i  = v.o;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " mem_valid"}, 32'(bus.mem_valid_o), 32'(v.e_mv));
        chk({tag, " mem_reg_write"}, 32'(bus.mem_reg_write_o), 32'(v.e_rw));
        chk({tag, " redirect"}, 32'(bus.redirect_o), 32'(v.e_redir));
        chk({tag, " taken_cnt"}, 32'(bus.taken_cnt_o), 32'(v.e_cnt));
        if (v.chk) begin
            chk({tag, " mem_result"}, bus.mem_result_o, v.e_res);
            chk({tag, " mem_rd"}, 32'(bus.mem_rd_o), 32'(v.e_rd));
        end
        if (v.e_redir)
            chk({tag, " redirect_pc"}, bus.redirect_pc_o, v.e_rpc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        // fields: valid,branch,jal,jalr,f3,pc,imm,rd,rw,alu,z,n,c,o | mv,res,rd,rw,redir,rpc,cnt,chk
        vecs[0]  = '{T,F,T,F,3'b000,32'h100,32'h20,5'd1,T,32'h0,F,F,F,F, T,32'h104,5'd1,T,T,32'h120,16'd1,T};
        vecs[1]  = fill(32'h55, 5'd2, 16'd1);
        vecs[2]  = fill(32'h66, 5'd3, 16'd1);
        vecs[3]  = '{T,T,F,F,3'b000,32'h200,32'h10,5'd0,F,32'h0,T,F,T,F, T,32'h0,5'd0,F,T,32'h210,16'd2,T};
        vecs[4]  = '{F,F,F,F,3'b000,32'h0,32'h0,5'd0,F,32'h0,F,F,F,F, F,32'h0,5'd0,F,F,32'h0,16'd2,F};
        vecs[5]  = fill(32'h1, 5'd4, 16'd2);
        vecs[6]  = fill(32'h2, 5'd5, 16'd2);
        vecs[7]  = '{T,T,F,F,3'b100,32'h300,32'h8,5'd0,F,32'h0,F,T,T,T, T,32'h0,5'd0,F,F,32'h0,16'd2,T};
        vecs[8]  = '{T,T,F,F,3'b110,32'h310,32'h40,5'd0,F,32'hFFFF_FFF0,F,T,F,F, T,32'hFFFF_FFF0,5'd0,F,T,32'h350,16'd3,T};
        vecs[9]  = fill(32'h3, 5'd6, 16'd3);
        vecs[10] = fill(32'h4, 5'd7, 16'd3);
        vecs[11] = '{T,T,F,F,3'b111,32'h320,32'hFFFF_FFF0,5'd0,F,32'h5,F,F,T,F, T,32'h5,5'd0,F,T,32'h310,16'd4,T};
        vecs[12] = fill(32'h5, 5'd8, 16'd4);
        vecs[13] = fill(32'h6, 5'd9, 16'd4);
        vecs[14] = '{T,T,F,F,3'b001,32'h330,32'h40,5'd0,T,32'h0,T,F,T,F, T,32'h0,5'd0,F,F,32'h0,16'd4,T};
        vecs[15] = '{T,T,F,F,3'b010,32'h340,32'h40,5'd0,F,32'h9,T,T,F,F, T,32'h9,5'd0,F,F,32'h0,16'd4,T};
        vecs[16] = '{T,F,F,T,3'b000,32'h400,32'h3,5'd5,T,32'h2003,F,F,F,F, T,32'h404,5'd5,T,T,32'h2002,16'd5,T};
        vecs[17] = '{T,F,T,F,3'b000,32'h500,32'h40,5'd1,T,32'h0,F,F,F,F, F,32'h0,5'd1,F,F,32'h0,16'd5,F};
        vecs[18] = fill(32'h7, 5'd10, 16'd5);
        vecs[19] = '{T,F,F,F,3'b000,32'h410,32'h0,5'd7,T,32'h77,F,F,F,F, T,32'h77,5'd7,T,F,32'h0,16'd5,T};
        vecs[20] = '{T,F,T,F,3'b000,32'hFFFF_FFFC,32'h8,5'd1,T,32'h0,F,F,F,F, T,32'h0,5'd1,T,T,32'h4,16'd6,T};
        vecs[21] = fill(32'h8, 5'd11, 16'd6);
        vecs[22] = fill(32'h9, 5'd12, 16'd6);
        vecs[23] = '{T,T,T,T,3'b000,32'h600,32'h100,5'd3,F,32'h801,T,F,T,F, T,32'h604,5'd3,F,T,32'h800,16'd7,T};
        vecs[24] = fill(32'hA, 5'd13, 16'd7);
        vecs[25] = fill(32'hB, 5'd14, 16'd7);

        sat.valid_i = 1'b0; sat.stall_i = 1'b0; sat.branch_i = 1'b0; sat.jal_i = 1'b0;
        sat.jalr_i = 1'b0; sat.funct3_i = 3'b000; sat.pc_i = 32'h0; sat.imm_i = 32'h10;
        sat.rd_i = 5'd1; sat.reg_write_i = 1'b1; sat.alu_result_i = 32'h0;
        sat.zero_i = 1'b0; sat.negative_i = 1'b0; sat.carry_i = 1'b0; sat.over_flow_i = 1'b0;

        // Reset held with a taken JAL presented
        drive(vecs[0]);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst mem_valid", 32'(bus.mem_valid_o), 32'h0);
            chk("rst mem_result", bus.mem_result_o, 32'h0);
            chk("rst mem_rd", 32'(bus.mem_rd_o), 32'h0);
            chk("rst mem_reg_write", 32'(bus.mem_reg_write_o), 32'h0);
            chk("rst redirect", 32'(bus.redirect_o), 32'h0);
            chk("rst redirect_pc", bus.redirect_pc_o, 32'h0);
            chk("rst taken_cnt", 32'(bus.taken_cnt_o), 32'h0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i]);
            step();
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Redirect held through a 3-cycle stall; kill slots count only after it
        v = '{T,T,F,F,3'b000,32'h700,32'h20,5'd0,F,32'h0,T,F,T,F, T,32'h0,5'd0,F,T,32'h720,16'd8,T};
        drive(v);
        step();
        check_vec("stall br", v);
        drive(fill(32'hC, 5'd15, 16'd8));
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall redirect", 32'(bus.redirect_o), 32'h1);
            chk("stall taken_cnt", 32'(bus.taken_cnt_o), 32'd8);
        end
        bus.stall_i = 1'b0;
        step();
        chk("post-stall redirect", 32'(bus.redirect_o), 32'h0);
        chk("post-stall kill1 mem_valid", 32'(bus.mem_valid_o), 32'h0);
        step();
        chk("post-stall kill2 mem_valid", 32'(bus.mem_valid_o), 32'h0);
        step();
        chk("post-stall live mem_valid", 32'(bus.mem_valid_o), 32'h1);
        chk("post-stall taken_cnt", 32'(bus.taken_cnt_o), 32'd8);

        // Reset in the middle of a flush abandons it
        v = '{T,F,T,F,3'b000,32'h0,32'h40,5'd1,T,32'h0,F,F,F,F, T,32'h4,5'd1,T,T,32'h40,16'd9,T};
        drive(v);
        step();
        check_vec("midrst jal", v);
        rst_n = 1'b0;
        drive(fill(32'h99, 5'd4, 16'd0));
        step();
        chk("midrst taken_cnt", 32'(bus.taken_cnt_o), 32'h0);
        chk("midrst redirect", 32'(bus.redirect_o), 32'h0);
        rst_n = 1'b1;
        step();
        chk("midrst live mem_valid", 32'(bus.mem_valid_o), 32'h1);
        chk("midrst live mem_reg_write", 32'(bus.mem_reg_write_o), 32'h1);
        chk("midrst live mem_result", bus.mem_result_o, 32'h99);

        // Saturating counter on the CNT_W=4, FLUSH_SLOTS=1 instance
        bus.valid_i = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            sat.valid_i = 1'b1;
            sat.jal_i   = 1'b1;
            step();
            chk($sformatf("sat redirect %0d", i), 32'(sat.redirect_o), 32'h1);
            chk($sformatf("sat taken_cnt %0d", i), 32'(sat.taken_cnt_o), (i > 15) ? 32'd15 : 32'(i));
            sat.jal_i = 1'b0;
            step();
            chk($sformatf("sat kill mem_valid %0d", i), 32'(sat.mem_valid_o), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
